seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative signed integer divider for the processor's multdiv unit.
- Uses the subtract direction of the carry-lookahead adder datapath: the adder is driven with the inverted divisor and carry-in 1, giving one restoring subtract-and-shift step per clock.
- Accepts a one-cycle start pulse, runs multi-cycle, and returns quotient, remainder and exception with a one-cycle ready pulse.

Parameters:
- WIDTH, 32, operand/result width in bits (even, >= 4).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ctrl_start  input  1  start pulse; operands sampled on the same edge.
- operand_A  input  WIDTH  dividend, two's complement.
- operand_B  input  WIDTH  divisor, two's complement.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows the dividend.
- exception  output  1  divide-by-zero or overflow flag for the last operation.
- result_rdy  output  1  one-cycle pulse; results are valid in this cycle and held afterwards.
- busy  output  1  high in every state except IDLE and DONE.

Behaviour:
- Reset (synchronous, active-high): state IDLE; quotient, remainder, exception, result_rdy and busy all 0. Reset mid-operation aborts with no result_rdy.
- States: IDLE, SETUP, ITER, FIXUP, DONE.
- IDLE -> SETUP: on ctrl_start. Latch sign_q = A[msb]^B[msb] and sign_r = A[msb].
- SETUP (1 cycle):
  - Form |A| and |B| as WIDTH-bit unsigned values (0x8000_0000 magnitude is legal).
  - Clear the partial remainder (WIDTH+1 bits).
  - Load the quotient shift register with |A|.
  - Iteration counter = WIDTH.
  - B == 0: go to DONE with quotient 0, remainder = A, exception 1.
  - Otherwise go to ITER.
- ITER (exactly WIDTH cycles), each cycle:
  - Shift {rem, q} left by 1.
  - diff = rem - |B| (adder with ~B, cin 1).
  - No borrow: rem = diff, q[0] = 1. Borrow: rem unchanged, q[0] = 0.
  - Decrement the counter; go to FIXUP when the counter reaches 1.
- FIXUP (1 cycle):
  - Negate q if sign_q; negate rem if sign_r.
  - A == min-negative and B == -1: quotient = 0x8000_0000, remainder 0, exception 1.
- DONE: result_rdy = 1 for one cycle, busy 0, then go to IDLE. Outputs stay stable until the next FIXUP or DONE writes them.
- Latency: result_rdy is high exactly WIDTH+3 cycles after the edge that sampled ctrl_start (35 for WIDTH=32). Divide-by-zero: 2 cycles.
- ctrl_start while busy is ignored, and operands are not resampled.
- ctrl_start during DONE is accepted (back-to-back); the next SETUP follows directly.
- Outputs do not change while busy until FIXUP.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in SETUP, if |A| < |B| (and B != 0), skip ITER and go to FIXUP with q = 0 and rem = |A|. result_rdy then comes 3 cycles after start. Signs are applied as normal: quotient 0, remainder = A.
- Undefined: every nonzero-divisor operation takes the full WIDTH+3 cycles.

Test Plan:
- A=100, B=7, start pulse -> result_rdy exactly 35 cycles later; quotient 14, remainder 2, exception 0, busy high in between.
- A=-100, B=7 -> quotient -14 (0xFFFF_FFF2), remainder -2. A=100, B=-7 -> quotient -14, remainder 2.
- A=0x8000_0000, B=-1 -> quotient 0x8000_0000, remainder 0, exception 1. A=5, B=0 -> result_rdy 2 cycles after start, quotient 0, remainder 5, exception 1.
- Back-to-back: 100/7, then start asserted in the DONE cycle with 9/3 -> second result_rdy 35 cycles later, quotient 3, remainder 0. A start pulse mid-operation is ignored.
- Reset asserted in the 10th ITER cycle -> next cycle IDLE, all outputs 0, no result_rdy. A new 100/7 afterwards completes correctly.
- DIV_EARLY_EXIT_EN defined, A=3, B=10 -> result_rdy 3 cycles after start, quotient 0, remainder 3. Undefined -> same values at 35 cycles.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative signed divider: one restoring subtract-and-shift step per clock.
// Optional DIV_EARLY_EXIT_EN skips the iterations when |A| < |B|.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             exception,
    output logic             result_rdy,
    output logic             busy
);
    // state | meaning
    // IDLE  | waiting for ctrl_start
    // SETUP | form operand magnitudes, catch divide-by-zero
    // ITER  | WIDTH restoring subtract-and-shift steps
    // FIXUP | apply signs, catch min-negative / -1 overflow
    // DONE  | result_rdy follows next cycle; may accept a new start

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg, b_reg, b_abs, q_reg, rem_reg;
    logic             sign_q, sign_r;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] sum;
    logic             no_borrow;
    logic             unused_diff_msb;
    logic             overflow;

    assign a_mag = a_reg[WIDTH-1] ? -a_reg : a_reg;
    assign b_mag = b_reg[WIDTH-1] ? -b_reg : b_reg;

    // Partial remainder minus |B| through the adder: add ~B with carry-in 1.
    assign shifted         = {rem_reg, q_reg[WIDTH-1]};
    assign sum             = {1'b0, shifted} + {1'b0, ~{1'b0, b_abs}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign no_borrow       = sum[WIDTH+1];
    assign unused_diff_msb = sum[WIDTH];
    assign overflow        = (a_reg == MIN_NEG) && (b_reg == {WIDTH{1'b1}});

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            b_abs      <= '0;
            q_reg      <= '0;
            rem_reg    <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            count      <= '0;
            quotient   <= '0;
            remainder  <= '0;
            exception  <= 1'b0;
            result_rdy <= 1'b0;
            busy       <= 1'b0;
        end else begin
            result_rdy <= (state == DONE);
            case (state)
                IDLE, DONE: begin
                    if (ctrl_start) begin
                        a_reg  <= operand_A;
                        b_reg  <= operand_B;
                        sign_q <= operand_A[WIDTH-1] ^ operand_B[WIDTH-1];
                        sign_r <= operand_A[WIDTH-1];
                        state  <= SETUP;
                        busy   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SETUP: begin
                    b_abs   <= b_mag;
                    rem_reg <= '0;
                    q_reg   <= a_mag;
                    count   <= CW'(WIDTH);
                    if (b_reg == '0) begin
                        quotient  <= '0;
                        remainder <= a_reg;
                        exception <= 1'b1;
                        state     <= DONE;
                        busy      <= 1'b0;
`ifdef DIV_EARLY_EXIT_EN
                    end else if (a_mag < b_mag) begin
                        q_reg   <= '0;
                        rem_reg <= a_mag;
                        state   <= FIXUP;
`endif
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    q_reg   <= {q_reg[WIDTH-2:0], no_borrow};
                    rem_reg <= no_borrow ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
                    count   <= count - CW'(1);
                    if (count == CW'(1))
                        state <= FIXUP;
                end
                FIXUP: begin
                    if (overflow) begin
                        quotient  <= MIN_NEG;
                        remainder <= '0;
                        exception <= 1'b1;
                    end else begin
                        quotient  <= sign_q ? -q_reg : q_reg;
                        remainder <= sign_r ? -rem_reg : rem_reg;
                        exception <= 1'b0;
                    end
                    state <= DONE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32).
module tb_seq_divider;
    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_start;
    logic [31:0] operand_A, operand_B;
    logic [31:0] quotient, remainder;
    logic        exception, result_rdy, busy;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .ctrl_start (ctrl_start),
        .operand_A  (operand_A),
        .operand_B  (operand_B),
        .quotient   (quotient),
        .remainder  (remainder),
        .exception  (exception),
        .result_rdy (result_rdy),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Issue one start pulse; return cycles from the sampling edge to result_rdy
    // and the number of cycles busy was seen high before it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        @(negedge clock);
        operand_A  = a;
        operand_B  = b;
        ctrl_start = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!result_rdy && lat < 100) begin
            @(negedge clock);
            lat++;
            if (busy && !result_rdy) bcnt++;
        end
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        ctrl_start = 1'b0;
        operand_A  = '0;
        operand_B  = '0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({quotient, remainder, exception, result_rdy, busy} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got q=%h r=%h e=%b rdy=%b busy=%b, want all 0",
                     quotient, remainder, exception, result_rdy, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bcnt;
        run_op(32'd100, 32'd7, lat, bcnt);
        n_cmp++;
        if (lat !== 35) begin n_err++; $display("FAIL basic_latency: got %0d want 35", lat); end
        n_cmp++;
        if (bcnt !== 34) begin n_err++; $display("FAIL basic_busy: busy high %0d cycles want 34", bcnt); end
        n_cmp++;
        if (quotient !== 32'd14) begin n_err++; $display("FAIL basic_q: got %h want %h", quotient, 32'd14); end
        n_cmp++;
        if (remainder !== 32'd2) begin n_err++; $display("FAIL basic_r: got %h want %h", remainder, 32'd2); end
        n_cmp++;
        if (exception !== 1'b0) begin n_err++; $display("FAIL basic_exc: got %b want 0", exception); end
        @(negedge clock);
        n_cmp++;
        if ({result_rdy, quotient, remainder} !== {1'b0, 32'd14, 32'd2}) begin
            n_err++;
            $display("FAIL basic_hold: got rdy=%b q=%h r=%h want rdy=0 q=e r=2",
                     result_rdy, quotient, remainder);
        end
    endtask

    task automatic test_signed;
        logic [31:0] va [10] = '{32'hFFFF_FF9C, 32'd100,      32'hFFFF_FF9C, 32'h8000_0000, 32'd5,
                                 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFB, 32'h7FFF_FFFF};
        logic [31:0] vb [10] = '{32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd0,
                                 32'd1,         32'd2,         32'd2,         32'd0,         32'h7FFF_FFFF};
        logic [31:0] vq [10] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14,        32'h8000_0000, 32'd0,
                                 32'h8000_0000, 32'hC000_0000, 32'hFFFF_FFFD, 32'd0,         32'd1};
        logic [31:0] vr [10] = '{32'hFFFF_FFFE, 32'd2,         32'hFFFF_FFFE, 32'd0,         32'd5,
                                 32'd0,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd0};
        logic        ve [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat, bcnt, want_lat;
        for (int i = 0; i < 10; i++) begin
            run_op(va[i], vb[i], lat, bcnt);
            want_lat = (vb[i] == 32'd0) ? 2 : 35;
            n_cmp++;
            if (lat !== want_lat) begin
                n_err++;
                $display("FAIL signed_latency[%0d]: got %0d want %0d", i, lat, want_lat);
            end
            n_cmp++;
            if ({quotient, remainder, exception} !== {vq[i], vr[i], ve[i]}) begin
                n_err++;
                $display("FAIL signed_result[%0d] %h/%h: got q=%h r=%h e=%b want q=%h r=%h e=%b",
                         i, va[i], vb[i], quotient, remainder, exception, vq[i], vr[i], ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int k, lat;
        @(negedge clock);
        operand_A  = 32'd100;
        operand_B  = 32'd7;
        ctrl_start = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (k !== 34) begin n_err++; $display("FAIL b2b_done_cycle: got %0d want 34", k); end
        // Now in DONE: start the second operation.
        operand_A  = 32'd9;
        operand_B  = 32'd3;
        ctrl_start = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        n_cmp++;
        if ({result_rdy, busy, quotient} !== {1'b1, 1'b1, 32'd14}) begin
            n_err++;
            $display("FAIL b2b_first: got rdy=%b busy=%b q=%h want rdy=1 busy=1 q=e",
                     result_rdy, busy, quotient);
        end
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (lat == 10) begin
                operand_A  = 32'd50;
                operand_B  = 32'd5;
                ctrl_start = 1'b1;
            end else begin
                ctrl_start = 1'b0;
            end
            if (lat == 20) begin
                n_cmp++;
                if (quotient !== 32'd14) begin
                    n_err++;
                    $display("FAIL b2b_hold_busy: got q=%h want %h", quotient, 32'd14);
                end
            end
        end while (!result_rdy && lat < 100);
        ctrl_start = 1'b0;
        n_cmp++;
        if (lat !== 35) begin n_err++; $display("FAIL b2b_latency: got %0d want 35", lat); end
        n_cmp++;
        if ({quotient, remainder, exception} !== {32'd3, 32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_result: got q=%h r=%h e=%b want q=3 r=0 e=0",
                     quotient, remainder, exception);
        end
    endtask

    task automatic test_reset_mid;
        int seen, lat, bcnt;
        @(negedge clock);
        operand_A  = 32'd100;
        operand_B  = 32'd7;
        ctrl_start = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_cmp++;
        if ({quotient, remainder, exception, result_rdy, busy} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got q=%h r=%h e=%b rdy=%b busy=%b, want all 0",
                     quotient, remainder, exception, result_rdy, busy);
        end
        seen = 0;
        repeat (50) begin
            @(negedge clock);
            if (result_rdy || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL reset_mid_quiet: activity in %0d cycles want 0", seen); end
        run_op(32'd100, 32'd7, lat, bcnt);
        n_cmp++;
        if ({lat, quotient, remainder, exception} !== {32'd35, 32'd14, 32'd2, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_rerun: got lat=%0d q=%h r=%h e=%b want lat=35 q=e r=2 e=0",
                     lat, quotient, remainder, exception);
        end
    endtask

    task automatic test_early_exit;
        int lat, bcnt, want_lat;
`ifdef DIV_EARLY_EXIT_EN
        want_lat = 3;
`else
        want_lat = 35;
`endif
        run_op(32'd3, 32'd10, lat, bcnt);
        n_cmp++;
        if (lat !== want_lat) begin n_err++; $display("FAIL early_latency: got %0d want %0d", lat, want_lat); end
        n_cmp++;
        if ({quotient, remainder, exception} !== {32'd0, 32'd3, 1'b0}) begin
            n_err++;
            $display("FAIL early_result: got q=%h r=%h e=%b want q=0 r=3 e=0",
                     quotient, remainder, exception);
        end
        run_op(32'hFFFF_FFFD, 32'd10, lat, bcnt);
        n_cmp++;
        if ({lat, quotient, remainder} !== {want_lat, 32'd0, 32'hFFFF_FFFD}) begin
            n_err++;
            $display("FAIL early_neg: got lat=%0d q=%h r=%h want lat=%0d q=0 r=fffffffd",
                     lat, quotient, remainder, want_lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_back_to_back();
        test_reset_mid();
        test_early_exit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
